// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Holds the scan FSM state type and a one-hot to index converter.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } kp_state_t;

    localparam int MAX_LINES = 8;

    // Assumes at most one bit set; callers qualify with a one-hot test first.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_LINES-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_LINES; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Stable-cycle counter: done goes high on the CYC-th consecutive cycle with match set.
// Any cycle with clear asserted or match low restarts the count from zero.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int CYC = 20000,
    parameter int W   = $clog2(CYC + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic match,
    input  logic clear,
    output logic done
);

    logic [W-1:0] cnt;

    assign done = match && (cnt == W'(CYC - 1));

    // Saturates at CYC-1 so the count never wraps while the owner lingers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || !match) begin
            cnt <= '0;
        end else if (!done) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/matrix_keypad_scan.sv
// Row-scanning keypad controller with press/release debounce and one-key acceptance.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
//
// state      | meaning
// SCAN       | drive one row, settle, sample; advance row unless exactly one column is high
// DB_PRESS   | row frozen; count cycles the latched column stays the only one high
// HELD       | key accepted; wait for all columns to drop
// DB_RELEASE | count all-zero cycles; a column returning goes back to HELD
module matrix_keypad_scan
    import keypad_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SETTLE_CYC   = 4,
    parameter int DEBOUNCE_CYC = 20000,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_CYC   = 100000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [COLS-1:0]                 col,
    output logic [ROWS-1:0]                 rows,
    output logic [$clog2(ROWS*COLS)-1:0]    key_code,
    output logic                            key_valid,
    output logic                            key_release,
    output logic                            key_held
);

    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int KW    = $clog2(ROWS * COLS);
    localparam int T_A   = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
    localparam int T_B   = (REPEAT_DELAY > REPEAT_CYC) ? REPEAT_DELAY : REPEAT_CYC;
    localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int TW    = $clog2(T_MAX + 1);

    logic [COLS-1:0] col_meta;
    logic [COLS-1:0] col_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta <= '0;
            col_sync <= '0;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    kp_state_t       state;
    logic [RW-1:0]   row_idx;
    logic [RW-1:0]   row_next;
    logic [CW-1:0]   lat_col;
    logic [COLS-1:0] lat_onehot;
    logic [TW-1:0]   settle_cnt;
    logic            db_match;
    logic            db_clear;
    logic            db_done;
`ifdef KEYPAD_REPEAT_EN
    logic [TW-1:0]   rpt_cnt;
`endif

    assign row_next = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;

    always_comb begin
        db_match = 1'b0;
        case (state)
            DB_PRESS:   db_match = (col_sync == lat_onehot);
            DB_RELEASE: db_match = (col_sync == '0);
            default:    db_match = 1'b0;
        endcase
    end

    assign db_clear = !((state == DB_PRESS) || (state == DB_RELEASE));

    keypad_debounce #(
        .CYC (DEBOUNCE_CYC),
        .W   (TW)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .match (db_match),
        .clear (db_clear),
        .done  (db_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SCAN;
            rows        <= ROWS'(1);
            row_idx     <= '0;
            lat_col     <= '0;
            lat_onehot  <= '0;
            settle_cnt  <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_held    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt     <= '0;
`endif
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                SCAN: begin
                    // Sampling one cycle past the settle window lets the synchronizer catch up with the new row.
                    if (settle_cnt == TW'(SETTLE_CYC)) begin
                        settle_cnt <= '0;
                        if ($onehot(col_sync)) begin
                            state      <= DB_PRESS;
                            lat_onehot <= col_sync;
                            lat_col    <= CW'(onehot_to_idx(8'(col_sync)));
                        end else begin
                            row_idx <= row_next;
                            rows    <= ROWS'(1) << row_next;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                DB_PRESS: begin
                    if (!db_match) begin
                        state   <= SCAN;
                        row_idx <= row_next;
                        rows    <= ROWS'(1) << row_next;
                    end else if (db_done) begin
                        state     <= HELD;
                        key_code  <= KW'(row_idx) * KW'(COLS) + KW'(lat_col);
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rpt_cnt   <= TW'(REPEAT_DELAY - 1);
`endif
                    end
                end
                HELD: begin
                    if (col_sync == '0) begin
                        state <= DB_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                        if (rpt_cnt != '0) rpt_cnt <= rpt_cnt - 1'b1;
`endif
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (rpt_cnt == '0) begin
                            key_valid <= 1'b1;
                            rpt_cnt   <= TW'(REPEAT_CYC - 1);
                        end else begin
                            rpt_cnt <= rpt_cnt - 1'b1;
                        end
`endif
                    end
                end
                DB_RELEASE: begin
`ifdef KEYPAD_REPEAT_EN
                    if (rpt_cnt != '0) rpt_cnt <= rpt_cnt - 1'b1;
`endif
                    if (col_sync != '0) begin
                        state <= HELD;
                    end else if (db_done) begin
                        state       <= SCAN;
                        key_release <= 1'b1;
                        key_held    <= 1'b0;
                        row_idx     <= row_next;
                        rows        <= ROWS'(1) << row_next;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule
